// File: rtl/ax_btb_update_arbiter.sv
// ax_btb_update_arbiter: gathers taken approximate-branch results from all
// integer issue lanes and serialises them into one buffered BTB write per cycle.
// Same-cycle results that share a branch PC are merged so that the youngest lane wins.
// Results that do not fit in the buffer are dropped (lowest lanes are kept) and counted.
module ax_btb_update_arbiter #(
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned PC_WIDTH    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [ISSUE_WIDTH-1:0]          brValid,
  input  logic [ISSUE_WIDTH-1:0]          brIsAX,
  input  logic [ISSUE_WIDTH-1:0]          brTaken,
  input  logic [ISSUE_WIDTH-1:0]          brIsCondBr,
  input  logic [ISSUE_WIDTH*PC_WIDTH-1:0] brAddr,
  input  logic [ISSUE_WIDTH*PC_WIDTH-1:0] apAddr,
  output logic                            wrValid,
  input  logic                            wrReady,
  output logic [PC_WIDTH-1:0]             wrAddr,
  output logic [PC_WIDTH-1:0]             wrTarget,
  output logic                            wrIsCondBr,
  output logic [$clog2(QUEUE_DEPTH):0]    count,
  output logic                            dropPulse,
  output logic [7:0]                      dropCount
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LN_W  = $clog2(ISSUE_WIDTH + 1);

  typedef struct packed {
    logic [PC_WIDTH-1:0] addr;
    logic [PC_WIDTH-1:0] target;
    logic                cond;
  } entry_t;

  entry_t             mem_q [QUEUE_DEPTH];
  entry_t             mem_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wr_valid_q, wr_valid_d;
  logic               drop_pulse_q, drop_pulse_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  logic [ISSUE_WIDTH-1:0] qual;
  logic [ISSUE_WIDTH-1:0] keep;
  logic                   pop;
  logic [CNT_W-1:0]       free_slots;
  logic [LN_W-1:0]        n_push;
  logic [LN_W-1:0]        n_drop;
  logic [8:0]             drop_sum;
  entry_t                 new_entry;
  entry_t                 head_entry;

  // Qualify lanes and merge same-PC results so only the highest lane survives
  always_comb begin
    qual = brValid & brIsAX & brTaken;
    keep = qual;
    for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
      for (int j = i + 1; j < int'(ISSUE_WIDTH); j++) begin
        if (qual[i] && qual[j] &&
            (brAddr[i*PC_WIDTH +: PC_WIDTH] == brAddr[j*PC_WIDTH +: PC_WIDTH])) begin
          keep[i] = 1'b0;
        end
      end
    end
  end

  // Queue next-state: pop at head, in-order pushes at tail, drop accounting, flush
  always_comb begin
    mem_d        = mem_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    drop_pulse_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    n_push       = '0;
    n_drop       = '0;
    new_entry    = '0;
    drop_sum     = '0;

    pop        = wr_valid_q & wrReady;
    // A pop in the same cycle releases its slot to this cycle's pushes
    free_slots = CNT_W'(QUEUE_DEPTH) - count_q + CNT_W'(pop);

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d = head_q + PTR_W'(pop);
      for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
        if (keep[i]) begin
          if (32'(n_push) < 32'(free_slots)) begin
            new_entry.addr   = brAddr[i*PC_WIDTH +: PC_WIDTH];
            new_entry.target = apAddr[i*PC_WIDTH +: PC_WIDTH];
            new_entry.cond   = brIsCondBr[i];
            mem_d[tail_d]    = new_entry;
            tail_d           = tail_d + PTR_W'(1);
            n_push           = n_push + LN_W'(1);
          end else begin
            n_drop = n_drop + LN_W'(1);
          end
        end
      end
      count_d      = count_q + CNT_W'(n_push) - CNT_W'(pop);
      drop_pulse_d = (n_drop != '0);
      drop_sum     = 9'(drop_cnt_q) + 9'(n_drop);
      drop_cnt_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

    wr_valid_d = (count_d != '0);
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      wr_valid_q   <= 1'b0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      wr_valid_q   <= wr_valid_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Payload storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_entry = mem_q[head_q];
  assign wrValid    = wr_valid_q;
  assign wrAddr     = head_entry.addr;
  assign wrTarget   = head_entry.target;
  assign wrIsCondBr = head_entry.cond;
  assign count      = count_q;
  assign dropPulse  = drop_pulse_q;
  assign dropCount  = drop_cnt_q;

endmodule

// File: doc/ax_btb_update_arbiter.md
AX_BTB_UPDATE_ARBITER -- requirements
Module: ax_btb_update_arbiter

Purpose: sits directly upstream of the AX branch target buffer. Collects taken approximate-branch results from all integer issue lanes, then serialises them into one buffered BTB write per cycle.

Interface
REQ-001 SHALL have parameter ISSUE_WIDTH, default 2, number of integer branch-result lanes.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, buffered update entries (power of two, >=2).
REQ-003 SHALL have parameter PC_WIDTH, default 32, address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  pipeline flush; discards all buffered updates.
REQ-007 SHALL have port brValid  input  ISSUE_WIDTH  per-lane result valid.
REQ-008 SHALL have port brIsAX  input  ISSUE_WIDTH  per-lane: branch is approximate.
REQ-009 SHALL have port brTaken  input  ISSUE_WIDTH  per-lane executed-taken.
REQ-010 SHALL have port brIsCondBr  input  ISSUE_WIDTH  per-lane conditional-branch flag.
REQ-011 SHALL have port brAddr  input  ISSUE_WIDTH x PC_WIDTH  branch PC per lane.
REQ-012 SHALL have port apAddr  input  ISSUE_WIDTH x PC_WIDTH  approximate target per lane.
REQ-013 SHALL have port wrValid  output  1  BTB write request valid.
REQ-014 SHALL have port wrReady  input  1  BTB accepts the write this cycle.
REQ-015 SHALL have port wrAddr / wrTarget  output  PC_WIDTH each  branch PC / target of the head entry.
REQ-016 SHALL have port wrIsCondBr  output  1  conditional flag of the head entry.
REQ-017 SHALL have port count  output  log2(QUEUE_DEPTH)+1  current occupancy.
REQ-018 SHALL have port dropPulse  output  1  one-cycle pulse: at least one qualifying result was dropped.
REQ-019 SHALL have port dropCount  output  8  saturating total of dropped results.

Function
REQ-020 A lane SHALL qualify when brValid & brIsAX & brTaken; all other lanes are ignored.
REQ-021 Qualifying lanes SHALL be enqueued in ascending lane order, up to ISSUE_WIDTH pushes per cycle.
REQ-022 If two qualifying lanes in the same cycle carry equal brAddr, only the highest-numbered lane SHALL be enqueued; the others are coalesced, not counted as drops.
REQ-023 wrValid SHALL equal (count != 0); wrAddr, wrTarget and wrIsCondBr SHALL be driven from the head entry.
REQ-024 Pop SHALL occur when wrValid & wrReady; head SHALL advance by one per cycle at most.
REQ-025 Latency: a result qualifying in cycle N SHALL be visible at the outputs in cycle N+1 at the earliest; it never bypasses combinationally.
REQ-026 Free slots in a cycle SHALL equal QUEUE_DEPTH - count + pop; a simultaneous pop frees a slot for same-cycle pushes.
REQ-027 When qualifying (post-coalesce) results exceed free slots, lowest lanes SHALL be kept; the excess SHALL be dropped.
REQ-028 On a drop, dropPulse SHALL be 1 in cycle N+1; dropCount SHALL add the number dropped, saturating at 255.
REQ-029 Head and tail pointers SHALL wrap modulo QUEUE_DEPTH; count SHALL never exceed QUEUE_DEPTH.
REQ-030 Under flush, count SHALL become 0 in the next cycle; same-cycle pushes and pops SHALL be ignored; dropCount SHALL be unchanged.
REQ-031 Entry order SHALL be preserved: writes leave in exact enqueue order.

Reset
REQ-032 When rst=0 at a clock edge, count=0, head=tail=0, wrValid=0, dropPulse=0 and dropCount=0 SHALL hold from the next cycle.
REQ-033 Reset SHALL override flush and all pushes; entry payload contents need not be cleared.
REQ-034 Reset asserted mid-operation SHALL discard all buffered entries; no write request SHALL appear while rst=0.

Verification
REQ-035 Single push: lane0 qualifies with brAddr=0x100 and apAddr=0x200; wrReady=1 -> cycle+1 shows wrValid=1, wrAddr=0x100, wrTarget=0x200; cycle+2 shows count=0.
REQ-036 Coalesce: lanes 0 and 1 both carry brAddr=0x40, with lane1 apAddr=0x80 -> exactly one entry with wrTarget=0x80 and count=1.
REQ-037 Overflow: wrReady=0 with 2 qualifying lanes for 3 cycles (depth 4) -> count=4; the third cycle's lanes are both dropped; dropPulse=1 once; dropCount=2.
REQ-038 Full with pop: count=4, wrReady=1, one lane qualifies -> no drop, count stays 4, order preserved.
REQ-039 Flush: count=3 and flush=1 with a lane qualifying -> next cycle count=0 and wrValid=0.
REQ-040 Reset mid-stream: count=2 and rst=0 for one cycle -> count=0, dropCount=0, wrValid=0; afterwards, normal pushes resume at pointer 0.
